// File: rtl/multicycle_control_unit.sv
// Multicycle ARM main controller: sequences one instruction over 2-5 states, holds NZCV and gates architectural writes.
// Outputs are combinational from the current state; flags update at the end of an execute state.
module multicycle_control_unit #(
    parameter int STATE_W = 4
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [3:0]         Cond,
    input  logic [1:0]         Op,
    input  logic [5:0]         Funct,
    input  logic [3:0]         Rd,
    input  logic [3:0]         ALUFlags,
    output logic               PCWrite,
    output logic               AdrSrc,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               RegWrite,
    output logic [1:0]         ResultSrc,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ALUControl,
    output logic [1:0]         ImmSrc,
    output logic [1:0]         RegSrc,
    output logic [STATE_W-1:0] State
);
    localparam logic [STATE_W-1:0] S_FETCH  = STATE_W'(0);
    localparam logic [STATE_W-1:0] S_DECODE = STATE_W'(1);
    localparam logic [STATE_W-1:0] S_MEMADR = STATE_W'(2);
    localparam logic [STATE_W-1:0] S_MEMRD  = STATE_W'(3);
    localparam logic [STATE_W-1:0] S_MEMWB  = STATE_W'(4);
    localparam logic [STATE_W-1:0] S_MEMWR  = STATE_W'(5);
    localparam logic [STATE_W-1:0] S_EXECR  = STATE_W'(6);
    localparam logic [STATE_W-1:0] S_EXECI  = STATE_W'(7);
    localparam logic [STATE_W-1:0] S_ALUWB  = STATE_W'(8);
    localparam logic [STATE_W-1:0] S_BRANCH = STATE_W'(9);

    logic [STATE_W-1:0] state, next_state;
    logic [3:0]         flags;
    logic               cond_ex;
    logic               is_cmp;
    logic               rd_pc;
    logic [1:0]         alu_dec;
    logic               pc_we, mem_we, ir_we, reg_we;
    logic               n_f, z_f, c_f, v_f;

    assign {n_f, z_f, c_f, v_f} = flags;
    assign is_cmp = (Funct[4:1] == 4'b1010);
    assign rd_pc  = (Rd == 4'd15);

    always_comb begin
        cond_ex = 1'b0;
        case (Cond)
            4'b0000: cond_ex = z_f;
            4'b0001: cond_ex = ~z_f;
            4'b0010: cond_ex = c_f;
            4'b0011: cond_ex = ~c_f;
            4'b0100: cond_ex = n_f;
            4'b0101: cond_ex = ~n_f;
            4'b0110: cond_ex = v_f;
            4'b0111: cond_ex = ~v_f;
            4'b1000: cond_ex = c_f & ~z_f;
            4'b1001: cond_ex = ~c_f | z_f;
            4'b1010: cond_ex = (n_f == v_f);
            4'b1011: cond_ex = (n_f != v_f);
            4'b1100: cond_ex = ~z_f & (n_f == v_f);
            4'b1101: cond_ex = z_f | (n_f != v_f);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    always_comb begin
        alu_dec = 2'b00;
        case (Funct[4:1])
            4'b0010, 4'b1010: alu_dec = 2'b01;
            4'b0000:          alu_dec = 2'b10;
            4'b1100:          alu_dec = 2'b11;
            default:          alu_dec = 2'b00;
        endcase
    end

    always_comb begin
        next_state = S_FETCH;
        case (state)
            S_FETCH:  next_state = S_DECODE;
            S_DECODE: begin
                case (Op)
                    2'b00:   next_state = Funct[5] ? S_EXECI : S_EXECR;
                    2'b01:   next_state = S_MEMADR;
                    2'b10:   next_state = S_BRANCH;
                    default: next_state = S_FETCH;
                endcase
            end
            S_MEMADR: next_state = Funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:  next_state = S_MEMWB;
            S_EXECR:  next_state = S_ALUWB;
            S_EXECI:  next_state = S_ALUWB;
            default:  next_state = S_FETCH;
        endcase
    end

    always_comb begin
        pc_we      = 1'b0;
        AdrSrc     = 1'b0;
        mem_we     = 1'b0;
        ir_we      = 1'b0;
        reg_we     = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ALUControl = 2'b00;
        case (state)
            S_FETCH: begin
                ir_we     = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                pc_we     = 1'b1;
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_MEMADR: ALUSrcB = 2'b01;
            S_MEMRD:  AdrSrc = 1'b1;
            // A load or ALU result aimed at R15 becomes a PC write instead.
            S_MEMWB: begin
                ResultSrc = 2'b01;
                pc_we     = cond_ex & rd_pc;
                reg_we    = cond_ex & ~rd_pc;
            end
            S_MEMWR: begin
                AdrSrc = 1'b1;
                mem_we = cond_ex;
            end
            S_EXECR: ALUControl = alu_dec;
            S_EXECI: begin
                ALUSrcB    = 2'b01;
                ALUControl = alu_dec;
            end
            S_ALUWB: begin
                pc_we  = cond_ex & ~is_cmp & rd_pc;
                reg_we = cond_ex & ~is_cmp & ~rd_pc;
            end
            S_BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                pc_we     = cond_ex;
            end
            default: ;
        endcase
    end

    assign PCWrite  = pc_we  & ~RST;
    assign MemWrite = mem_we & ~RST;
    assign IRWrite  = ir_we  & ~RST;
    assign RegWrite = reg_we & ~RST;
    assign ImmSrc   = Op;
    assign RegSrc   = {Op == 2'b01, Op == 2'b10};
    assign State    = state;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_FETCH;
            flags <= 4'b0000;
        end else begin
            state <= next_state;
            if ((state == S_EXECR || state == S_EXECI) && (Funct[0] || is_cmp) && cond_ex)
                flags <= ALUFlags;
        end
    end
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: instruction-level model predicts the state path and per-cycle control word.
module tb_multicycle_control_unit;
    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [3:0] Cond = 4'hE;
    logic [1:0] Op = 2'b00;
    logic [5:0] Funct = 6'd0;
    logic [3:0] Rd = 4'd0;
    logic [3:0] ALUFlags = 4'd0;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA;
    logic [1:0] ResultSrc, ALUSrcB, ALUControl, ImmSrc, RegSrc;
    logic [3:0] State;

    int total = 0;
    int bad = 0;
    logic [3:0] mflags = 4'b0000;

    multicycle_control_unit #(.STATE_W(4)) dut (
        .CLK(CLK), .RST(RST), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd), .ALUFlags(ALUFlags),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
        .ImmSrc(ImmSrc), .RegSrc(RegSrc), .State(State)
    );

    always #5 CLK = ~CLK;

    function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'd0: return z;          4'd1: return !z;
            4'd2: return cy;         4'd3: return !cy;
            4'd4: return n;          4'd5: return !n;
            4'd6: return v;          4'd7: return !v;
            4'd8: return cy && !z;   4'd9: return !cy || z;
            4'd10: return n == v;    4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Control word: {PCW,AdrSrc,MemW,IRW,RegW,ResultSrc,SrcA,SrcB,ALUCtl,ImmSrc,RegSrc,State}
    function automatic logic [19:0] expect_word(input int s, input logic [3:0] c, input logic [1:0] op,
                                                input logic [5:0] f, input logic [3:0] rd, input logic [3:0] fl);
        logic pcw = 0, adr = 0, mw = 0, irw = 0, rw = 0, sa = 0;
        logic [1:0] res = 0, sb = 0, alu = 0, alu_cmd;
        logic ce = cond_ok(c, fl);
        logic cmp = (f[4:1] == 4'b1010);
        case (f[4:1])
            4'b0010, 4'b1010: alu_cmd = 2'b01;
            4'b0000: alu_cmd = 2'b10;
            4'b1100: alu_cmd = 2'b11;
            default: alu_cmd = 2'b00;
        endcase
        case (s)
            0: begin irw = 1; sa = 1; sb = 2; res = 2; pcw = 1; end
            1: begin sa = 1; sb = 2; res = 2; end
            2: sb = 1;
            3: adr = 1;
            4: begin res = 1; if (rd == 15) pcw = ce; else rw = ce; end
            5: begin adr = 1; mw = ce; end
            6: alu = alu_cmd;
            7: begin sb = 1; alu = alu_cmd; end
            8: begin if (rd == 15) pcw = ce & !cmp; else rw = ce & !cmp; end
            9: begin sb = 1; res = 2; pcw = ce; end
            default: ;
        endcase
        return {pcw, adr, mw, irw, rw, res, sa, sb, alu, op, (op == 2'b01), (op == 2'b10), 4'(s)};
    endfunction

    function automatic logic [19:0] actual_word();
        return {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB,
                ALUControl, ImmSrc, RegSrc, State};
    endfunction

    // Runs one instruction from FETCH; abort_at >= 0 pulses RST during that step and abandons the rest.
    task automatic run_instr(input string name, input logic [3:0] c, input logic [1:0] op, input logic [5:0] f,
                             input logic [3:0] rd, input logic [3:0] af, input int abort_at);
        int seq[$];
        logic [19:0] exp_w, got_w;
        seq = {0, 1};
        case (op)
            2'b00: begin seq.push_back(f[5] ? 7 : 6); seq.push_back(8); end
            2'b01: begin
                seq.push_back(2);
                if (f[0]) begin seq.push_back(3); seq.push_back(4); end
                else seq.push_back(5);
            end
            2'b10: seq.push_back(9);
            default: ;
        endcase
        Cond = c; Op = op; Funct = f; Rd = rd; ALUFlags = af;
        foreach (seq[i]) begin
            if (i == abort_at) RST = 1'b1;
            @(negedge CLK);
            exp_w = expect_word(seq[i], c, op, f, rd, mflags);
            if (RST) begin
                exp_w[19] = 1'b0; exp_w[17] = 1'b0; exp_w[16] = 1'b0; exp_w[15] = 1'b0;
            end
            got_w = actual_word();
            total++;
            if (got_w !== exp_w) begin
                bad++;
                $display("FAIL %s step %0d: got %05h want %05h", name, i, got_w, exp_w);
            end
            if (!RST && (seq[i] == 6 || seq[i] == 7) && (f[0] || f[4:1] == 4'b1010) && cond_ok(c, mflags))
                mflags = af;
            @(posedge CLK); #1;
            if (i == abort_at) begin
                RST = 1'b0;
                mflags = 4'b0000;
                return;
            end
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge CLK);
            total++;
            if ({PCWrite, IRWrite, RegWrite, MemWrite} !== 4'b0000) begin
                bad++;
                $display("FAIL reset_writes cycle %0d: got %b want 0000", k, {PCWrite, IRWrite, RegWrite, MemWrite});
            end
            @(posedge CLK); #1;
        end
        RST = 1'b0;
        mflags = 4'b0000;
        @(negedge CLK);
        total++;
        if ({State, IRWrite, PCWrite, ALUSrcB} !== {4'd0, 1'b1, 1'b1, 2'b10}) begin
            bad++;
            $display("FAIL reset_release: got %b want 0000_1_1_10", {State, IRWrite, PCWrite, ALUSrcB});
        end
        @(posedge CLK); #1;
        // Release cycle consumed a FETCH; skip the DECODE of whatever is on the bus back to FETCH.
        Op = 2'b11;
        @(posedge CLK); #1;
    endtask

    task automatic test_data_proc();
        run_instr("add_imm", 4'hE, 2'b00, 6'b101000, 4'd1, 4'h0, -1);
        run_instr("orr_reg", 4'hE, 2'b00, 6'b011000, 4'd2, 4'hF, -1);
        run_instr("and_reg", 4'hE, 2'b00, 6'b000000, 4'd3, 4'h0, -1);
        run_instr("add_pc", 4'hE, 2'b00, 6'b001000, 4'd15, 4'h0, -1);
    endtask

    task automatic test_flags_branch();
        run_instr("subs_z", 4'hE, 2'b00, 6'b000101, 4'd1, 4'b0100, -1);
        run_instr("beq_taken", 4'h0, 2'b10, 6'b000000, 4'd0, 4'h0, -1);
        run_instr("subs_clr", 4'hE, 2'b00, 6'b000101, 4'd1, 4'b0000, -1);
        run_instr("beq_not", 4'h0, 2'b10, 6'b000000, 4'd0, 4'h0, -1);
        run_instr("cmp_nos", 4'hE, 2'b00, 6'b010100, 4'd0, 4'b1000, -1);
        run_instr("bmi_taken", 4'h4, 2'b10, 6'b000000, 4'd0, 4'h0, -1);
    endtask

    task automatic test_memory();
        run_instr("ldr", 4'hE, 2'b01, 6'b011001, 4'd3, 4'h0, -1);
        run_instr("str", 4'hE, 2'b01, 6'b011000, 4'd3, 4'h0, -1);
        run_instr("ldr_pc", 4'hE, 2'b01, 6'b011001, 4'd15, 4'h0, -1);
        run_instr("illegal", 4'hE, 2'b11, 6'b000000, 4'd0, 4'h0, -1);
    endtask

    task automatic test_reset_mid();
        run_instr("subs_set", 4'hE, 2'b00, 6'b000101, 4'd1, 4'b0100, -1);
        run_instr("ldr_abort", 4'hE, 2'b01, 6'b011001, 4'd3, 4'h0, 3);
        run_instr("beq_after_rst", 4'h0, 2'b10, 6'b000000, 4'd0, 4'h0, -1);
    endtask

    task automatic test_random();
        logic [3:0] c, rd, af;
        logic [1:0] op;
        logic [5:0] f;
        for (int k = 0; k < 60; k++) begin
            c  = 4'($urandom_range(0, 15));
            op = 2'($urandom_range(0, 3));
            f  = 6'($urandom);
            rd = 4'($urandom);
            af = 4'($urandom);
            if (op == 2'b00 && f[4:1] == 4'b1010 && rd == 4'd15) rd = 4'd14;
            run_instr("random", c, op, f, rd, af, -1);
        end
    endtask

    initial begin
        test_reset();
        test_data_proc();
        test_flags_branch();
        test_memory();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
